// File: rtl/ld_st_mem_sched_pkg.sv
// Shared types for the load/store data-memory scheduler.
// Holds the FSM encoding, funct3 codes and the latched request bundle.
package ld_st_mem_sched_pkg;

    localparam int ROB_IDX_MAX_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LD_WAIT,
        ST_WAIT,
        DRAIN
    } sched_state_t;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;

    // rob_idx is sized for the widest ROB; the scheduler uses the low bits
    typedef struct packed {
        logic [31:0]              addr;
        logic [31:0]              wdata;
        logic [3:0]               be;
        logic [2:0]               funct3;
        logic [ROB_IDX_MAX_W-1:0] rob_idx;
    } mem_req_t;

endpackage

// File: rtl/ld_st_lane_align.sv
// Byte-lane steering for the data-cache port.
// Produces lane mask, shifted store data and aligned/extended load data.
module ld_st_lane_align
    import ld_st_mem_sched_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_lane;

    assign o_wdata = i_wdata << {i_off, 3'b000};
    assign w_lane  = i_rdata >> {i_off, 3'b000};

    always_comb begin
        o_be = 4'b1111;
        case (i_funct3[1:0])
            2'b00:   o_be = 4'b0001 << i_off;
            2'b01:   o_be = 4'b0011 << {i_off[1], 1'b0};
            default: o_be = 4'b1111;
        endcase
    end

    always_comb begin
        o_rdata = w_lane;
        case (i_funct3)
            LB:      o_rdata = {{24{w_lane[7]}}, w_lane[7:0]};
            LH:      o_rdata = {{16{w_lane[15]}}, w_lane[15:0]};
            LBU:     o_rdata = {24'b0, w_lane[7:0]};
            LHU:     o_rdata = {16'b0, w_lane[15:0]};
            default: o_rdata = w_lane;
        endcase
    end

endmodule

// File: rtl/ld_st_mem_sched.sv
// Age-ordered single-port scheduler between load/store queue heads and dcache.
// Optional perf counters when LD_ST_SCHED_PERF_EN is defined.
module ld_st_mem_sched
    import ld_st_mem_sched_pkg::*;
#(
    parameter int ROB_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [ROB_IDX_W-1:0] rob_head_idx,
    input  logic                 ld_valid,
    input  logic                 ld_addr_ready,
    input  logic [ROB_IDX_W-1:0] ld_rob_idx,
    input  logic [31:0]          ld_addr,
    input  logic [2:0]           ld_funct3,
    output logic                 ld_pop,
    input  logic                 st_valid,
    input  logic                 st_addr_ready,
    input  logic                 st_data_ready,
    input  logic [ROB_IDX_W-1:0] st_rob_idx,
    input  logic [31:0]          st_addr,
    input  logic [31:0]          st_data,
    input  logic [2:0]           st_funct3,
    output logic                 st_pop,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [31:0]          mem_address,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_byte_enable,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_resp,
    output logic                 cdb_valid,
    output logic [ROB_IDX_W-1:0] cdb_rob_idx,
    output logic [31:0]          cdb_data,
    output logic                 st_done_valid,
    output logic [ROB_IDX_W-1:0] st_done_rob_idx
`ifdef LD_ST_SCHED_PERF_EN
    ,
    output logic [31:0]          perf_ld_cnt,
    output logic [31:0]          perf_st_cnt,
    output logic [31:0]          perf_blk_cnt
`endif
);

    sched_state_t r_state;
    sched_state_t w_next;
    mem_req_t     r_req;

    logic [ROB_IDX_W-1:0] w_ld_age;
    logic [ROB_IDX_W-1:0] w_st_age;
    logic                 w_st_elig;
    logic                 w_ld_elig;
    logic                 w_idle;
    logic [2:0]           w_la_funct3;
    logic [1:0]           w_la_off;
    logic [3:0]           w_st_be;
    logic [3:0]           w_ld_be;
    logic [31:0]          w_st_wdata;
    logic [31:0]          w_ld_rdata;
    logic [31:0]          w_unused_ld_wdata;
    logic [31:0]          w_unused_st_rdata;
    logic                 w_unused_rob_hi;

    assign w_ld_age  = ld_rob_idx - rob_head_idx;
    assign w_st_age  = st_rob_idx - rob_head_idx;
    assign w_st_elig = st_valid & st_addr_ready & st_data_ready
                     & (st_rob_idx == rob_head_idx);
    assign w_ld_elig = ld_valid & ld_addr_ready
                     & (~st_valid | (w_ld_age < w_st_age));
    assign w_idle    = (r_state == IDLE);

    // Load aligner sees the queue head while deciding, the latched request after
    assign w_la_funct3 = w_idle ? ld_funct3 : r_req.funct3;
    assign w_la_off    = w_idle ? ld_addr[1:0] : r_req.addr[1:0];

    ld_st_lane_align u_st_align (
        .i_funct3 (st_funct3),
        .i_off    (st_addr[1:0]),
        .i_wdata  (st_data),
        .i_rdata  (32'b0),
        .o_be     (w_st_be),
        .o_wdata  (w_st_wdata),
        .o_rdata  (w_unused_st_rdata)
    );

    ld_st_lane_align u_ld_align (
        .i_funct3 (w_la_funct3),
        .i_off    (w_la_off),
        .i_wdata  (32'b0),
        .i_rdata  (mem_rdata),
        .o_be     (w_ld_be),
        .o_wdata  (w_unused_ld_wdata),
        .o_rdata  (w_ld_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (!flush && w_st_elig) begin
                    w_next = ST_WAIT;
                end else if (!flush && w_ld_elig) begin
                    w_next = LD_WAIT;
                end
            end
            LD_WAIT: begin
                if (mem_resp) begin
                    w_next = IDLE;
                end else if (flush) begin
                    w_next = DRAIN;
                end
            end
            ST_WAIT: if (mem_resp) w_next = IDLE;
            DRAIN:   if (mem_resp) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ld_pop    = 1'b0;
        st_pop    = 1'b0;
        unique case (r_state)
            LD_WAIT: begin
                mem_read = 1'b1;
                ld_pop   = mem_resp & ~flush;
            end
            ST_WAIT: begin
                mem_write = 1'b1;
                st_pop    = mem_resp;
            end
            DRAIN:   mem_read = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req <= '0;
        end else if (w_idle && !flush) begin
            if (w_st_elig) begin
                r_req <= '{addr:    st_addr,
                           wdata:   w_st_wdata,
                           be:      w_st_be,
                           funct3:  st_funct3,
                           rob_idx: ROB_IDX_MAX_W'(st_rob_idx)};
            end else if (w_ld_elig) begin
                r_req <= '{addr:    ld_addr,
                           wdata:   32'b0,
                           be:      w_ld_be,
                           funct3:  ld_funct3,
                           rob_idx: ROB_IDX_MAX_W'(ld_rob_idx)};
            end
        end
    end

    assign mem_address     = {r_req.addr[31:2], 2'b00};
    assign mem_wdata       = r_req.wdata;
    assign mem_byte_enable = r_req.be;
    assign w_unused_rob_hi = ^r_req.rob_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_valid       <= 1'b0;
            cdb_rob_idx     <= '0;
            cdb_data        <= '0;
            st_done_valid   <= 1'b0;
            st_done_rob_idx <= '0;
        end else begin
            cdb_valid     <= ld_pop;
            st_done_valid <= st_pop;
            if (ld_pop) begin
                cdb_rob_idx <= r_req.rob_idx[ROB_IDX_W-1:0];
                cdb_data    <= w_ld_rdata;
            end
            if (st_pop) begin
                st_done_rob_idx <= r_req.rob_idx[ROB_IDX_W-1:0];
            end
        end
    end

`ifdef LD_ST_SCHED_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ld_cnt  <= '0;
            perf_st_cnt  <= '0;
            perf_blk_cnt <= '0;
        end else begin
            if (ld_pop) perf_ld_cnt <= perf_ld_cnt + 32'd1;
            if (st_pop) perf_st_cnt <= perf_st_cnt + 32'd1;
            if (w_idle && ld_valid && ld_addr_ready && !w_ld_elig) begin
                perf_blk_cnt <= perf_blk_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/ld_st_mem_sched.md
Name: ld_st_mem_sched

Overview:
- Single-port data-memory scheduler for the load and store circular queues.
- Each cycle, inspects the load-queue head and store-queue head and picks at most one eligible access, ordered by ROB age.
- Drives the data-cache port with a hold-until-resp handshake, then pops the served queue.
- Loads: aligns and extends read data and broadcasts it on the CDB. Stores: signals the ROB that the store is done. Handles flush without aborting an in-flight memory access.

Parameters:
- ROB_IDX_W, 5, width of ROB indices; age arithmetic is modulo 2**ROB_IDX_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  pipeline flush (mispredict); drop queued work, finish in-flight access silently
- rob_head_idx  in  ROB_IDX_W  index of oldest ROB entry
- ld_valid  in  1  load queue non-empty
- ld_addr_ready  in  1  head load address resolved
- ld_rob_idx  in  ROB_IDX_W  head load ROB index
- ld_addr  in  32  head load byte address
- ld_funct3  in  3  LB/LH/LW/LBU/LHU
- ld_pop  out  1  commit strobe to load queue
- st_valid  in  1  store queue non-empty
- st_addr_ready  in  1  head store address resolved
- st_data_ready  in  1  head store data resolved
- st_rob_idx  in  ROB_IDX_W  head store ROB index
- st_addr  in  32  head store byte address
- st_data  in  32  head store data
- st_funct3  in  3  SB/SH/SW
- st_pop  out  1  commit strobe to store queue
- mem_read  out  1  cache read request
- mem_write  out  1  cache write request
- mem_address  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  32  store data shifted to byte lane
- mem_byte_enable  out  4  lane mask
- mem_rdata  in  32  read data
- mem_resp  in  1  access complete
- cdb_valid  out  1  load result broadcast
- cdb_rob_idx  out  ROB_IDX_W  ROB tag of result
- cdb_data  out  32  aligned, extended load data
- st_done_valid  out  1  store completed
- st_done_rob_idx  out  ROB_IDX_W  ROB tag of completed store

Behaviour:
- Age: age(x) = x - rob_head_idx, truncated to ROB_IDX_W bits; smaller value is older.
- st_elig = st_valid & st_addr_ready & st_data_ready & (st_rob_idx == rob_head_idx). Stores are non-speculative.
- ld_elig = ld_valid & ld_addr_ready & (~st_valid | age(ld_rob_idx) < age(st_rob_idx)). No load passes an older store.
- Priority: st_elig over ld_elig (mutually exclusive by construction; the priority is still fixed).
- States:
  - IDLE: decide in IDLE with flush=0.
    - st_elig -> ST_WAIT, latching the request.
    - else ld_elig -> LD_WAIT, latching the request.
    - flush in IDLE keeps IDLE.
  - LD_WAIT:
    - mem_read=1 from latched registers; address and lanes stay stable until mem_resp.
    - mem_resp -> ld_pop=1 combinationally that cycle. Registered cdb_valid pulse next cycle with cdb_rob_idx and cdb_data. Then -> IDLE.
  - ST_WAIT:
    - mem_write=1.
    - mem_resp -> st_pop=1 combinationally. Registered st_done_valid pulse next cycle. Then -> IDLE.
  - DRAIN: entered from LD_WAIT on flush without mem_resp. Holds mem_read until mem_resp, then -> IDLE.
    - ld_pop=0 and no cdb pulse. The queue is already flushed.
- Flush in ST_WAIT has no effect. The store is at the ROB head and committed.
- Flush in LD_WAIT on the same cycle as mem_resp: no ld_pop, no cdb pulse, -> IDLE.
- Latency: head eligible cycle 0 -> mem_read/mem_write cycle 1. mem_resp in cycle N -> pop in N, cdb_valid or st_done_valid in N+1.
- Back-to-back: IDLE always costs one cycle, so there are at most one access per two cycles.
- Byte enables:
  - B: 4'b0001<<a[1:0]
  - H: 4'b0011<<{a[1],1'b0}
  - W: 4'b1111
  - mem_wdata = st_data << (8*a[1:0]). Misaligned addresses are not checked (upstream guarantees alignment).
- Load data: lane = mem_rdata >> (8*a[1:0]). LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Reset (asynchronous): state IDLE. Every output is 0: mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, ld_pop, st_pop, cdb_valid, cdb_rob_idx, cdb_data, st_done_valid, st_done_rob_idx, and all latched request registers. Reset mid-access abandons the access.
- ROB wrap: rob_head_idx=31, ld_rob_idx=1, st_rob_idx=0 gives age 2 vs 1, so the store is older and the load is blocked.

Optional Feature:
- Macro LD_ST_SCHED_PERF_EN.
- Defined: adds outputs perf_ld_cnt, perf_st_cnt, perf_blk_cnt (32 bits each, reset 0, wrapping).
  - perf_ld_cnt / perf_st_cnt increment on ld_pop / st_pop.
  - perf_blk_cnt increments each IDLE cycle with ld_valid & ld_addr_ready & ~ld_elig.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Add to Ld_St_structs:
  - sched_state_t enum (IDLE, LD_WAIT, ST_WAIT, DRAIN)
  - funct3 localparams (LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2)
  - mem_req_t struct (addr, wdata, be, funct3, rob_idx)
- Sub-module ld_st_lane_align (combinational): funct3 + addr[1:0] -> byte enable, shifted wdata, extended rdata. It is instantiated once for the store path and once for the load path.

Test Plan:
- Load LB, addr 0x103, mem_rdata 0x80AABBCC, 1-cycle resp -> mem_address 0x100, be 4'b1000, ld_pop in resp cycle, next cycle cdb_data 0xFFFFFF80 with cdb_rob_idx equal to ld_rob_idx.
- Store SH, addr 0x206, data 0x1234, st_rob_idx=rob_head_idx=7 -> mem_write, be 4'b1100, wdata 0x12340000, st_pop, then st_done_rob_idx=7. With rob_head_idx=6 there is no mem_write.
- Wrap ordering: rob_head 31, store idx 0 not data-ready, load idx 1 ready -> no mem_read. Set rob_head 0 and st_data_ready -> store issues first, then the load.
- Flush in LD_WAIT with mem_resp delayed 3 cycles -> mem_read held until resp, no ld_pop, no cdb_valid, back to IDLE.
- Async reset asserted mid-ST_WAIT between clock edges -> all outputs 0 immediately, state IDLE, no st_pop.
- With LD_ST_SCHED_PERF_EN defined, 3 loads, 2 stores, and 4 blocked-load idle cycles -> counters read 3, 2, 4.
